// File: rtl/riscv_pmem_loader.sv
// rtl/riscv_pmem_loader.sv - instruction memory with a byte-stream image loader that holds the core in reset
// Optional image checksum: define PMEM_LOADER_CHECKSUM_EN.
module riscv_pmem_loader #(
  parameter int ILen      = 32,
  parameter int AddrWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] pmem_addr_i,
  output logic [ILen-1:0]      pmem_rdata_o,
  input  logic                 load_valid_i,
  output logic                 load_ready_o,
  input  logic [7:0]           load_data_i,
  input  logic                 load_last_i,
  input  logic                 reload_i,
  output logic                 core_rst_o,
  output logic [AddrWidth-2:0] words_loaded_o,
  output logic                 overflow_o,
  output logic [7:0]           checksum_o
);

  localparam int Depth = 2 ** (AddrWidth - 2);
  localparam int WaW   = AddrWidth - 2;
  localparam int WlW   = AddrWidth - 1;

  localparam logic [1:0] StLoad  = 2'd0;
  localparam logic [1:0] StFlush = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;

  logic [1:0]      state;
  logic [1:0]      byte_cnt;
  logic [WaW-1:0]  word_addr;
  logic [ILen-1:0] word_buf;
  logic [WlW-1:0]  words_loaded;
  logic            overflow;
  logic [ILen-1:0] mem [Depth];

  logic            accept;
  logic            word_done;
  logic            do_write;
  logic [ILen-1:0] wdata;
  logic            unused_addr_bits;

  assign load_ready_o   = (state == StLoad);
  assign core_rst_o     = (state != StRun);
  assign words_loaded_o = words_loaded;
  assign overflow_o     = overflow;

  assign accept    = load_ready_o && load_valid_i;
  assign word_done = accept && ((byte_cnt == 2'd3) || load_last_i);
  // Once full, further words are consumed but dropped so the top word keeps its contents.
  assign do_write  = word_done && !overflow;
  // Lanes above byte_cnt are still zero in the buffer, which gives the padding of a short last word.
  assign wdata     = word_buf | (ILen'(load_data_i) << {byte_cnt, 3'b000});

  assign pmem_rdata_o     = mem[pmem_addr_i[AddrWidth-1:2]];
  assign unused_addr_bits = ^pmem_addr_i[1:0];

  always_ff @(posedge clk_i) begin
    if (do_write) begin
      mem[word_addr] <= wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= StLoad;
      byte_cnt     <= 2'd0;
      word_addr    <= '0;
      word_buf     <= '0;
      words_loaded <= '0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        StLoad: begin
          if (accept) begin
            if (word_done) begin
              byte_cnt <= 2'd0;
              word_buf <= '0;
              if (!overflow) begin
                words_loaded <= words_loaded + 1'b1;
                if (&word_addr) begin
                  overflow <= 1'b1;
                end else begin
                  word_addr <= word_addr + 1'b1;
                end
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              word_buf <= wdata;
            end
            if (load_last_i) begin
              state <= StFlush;
            end
          end
        end
        StFlush: begin
          state <= StRun;
        end
        StRun: begin
          if (reload_i) begin
            state        <= StLoad;
            byte_cnt     <= 2'd0;
            word_addr    <= '0;
            word_buf     <= '0;
            words_loaded <= '0;
            overflow     <= 1'b0;
          end
        end
        default: begin
          state <= StLoad;
        end
      endcase
    end
  end

`ifdef PMEM_LOADER_CHECKSUM_EN
  logic [7:0] checksum;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      checksum <= 8'd0;
    end else if ((state == StRun) && reload_i) begin
      checksum <= 8'd0;
    end else if (accept) begin
      checksum <= checksum + load_data_i;
    end
  end

  assign checksum_o = checksum;
`else
  assign checksum_o = 8'd0;
`endif

endmodule

// File: tb/tb_riscv_pmem_loader.sv
// tb/tb_riscv_pmem_loader.sv - scoreboard bench for riscv_pmem_loader (default depth and a 4-word instance)
module tb_riscv_pmem_loader;

  localparam int W_RDATA = 0;
  localparam int W_WL    = 1;
  localparam int W_OV    = 2;
  localparam int W_CS    = 3;
  localparam int W_CRST  = 4;
  localparam int W_READY = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr0;
  logic [3:0]  addr1;
  logic [31:0] rdata0, rdata1;
  logic        valid [2];
  logic        last [2];
  logic        reload [2];
  logic [7:0]  data [2];
  logic        ready0, ready1, crst0, crst1, ov0, ov1;
  logic [14:0] wl0;
  logic [2:0]  wl1;
  logic [7:0]  cs0, cs1;

  always #5 clk = ~clk;

  riscv_pmem_loader #(.ILen(32), .AddrWidth(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .pmem_addr_i(addr0), .pmem_rdata_o(rdata0),
    .load_valid_i(valid[0]), .load_ready_o(ready0), .load_data_i(data[0]),
    .load_last_i(last[0]), .reload_i(reload[0]), .core_rst_o(crst0),
    .words_loaded_o(wl0), .overflow_o(ov0), .checksum_o(cs0)
  );

  riscv_pmem_loader #(.ILen(32), .AddrWidth(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .pmem_addr_i(addr1), .pmem_rdata_o(rdata1),
    .load_valid_i(valid[1]), .load_ready_o(ready1), .load_data_i(data[1]),
    .load_last_i(last[1]), .reload_i(reload[1]), .core_rst_o(crst1),
    .words_loaded_o(wl1), .overflow_o(ov1), .checksum_o(cs1)
  );

  typedef struct {
    int          sel;
    int          what;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mmem [int];
  bit          in_run [2];

  function automatic logic [31:0] actual(input int sel, input int what);
    case (what)
      W_RDATA: return (sel == 0) ? rdata0 : rdata1;
      W_WL:    return (sel == 0) ? 32'(wl0) : 32'(wl1);
      W_OV:    return (sel == 0) ? {31'd0, ov0} : {31'd0, ov1};
      W_CS:    return (sel == 0) ? 32'(cs0) : 32'(cs1);
      W_CRST:  return (sel == 0) ? {31'd0, crst0} : {31'd0, crst1};
      default: return (sel == 0) ? {31'd0, ready0} : {31'd0, ready1};
    endcase
  endfunction

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? ready0 : ready1;
  endfunction

  exp_t        mon_e;
  logic [31:0] mon_a;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      mon_a = actual(mon_e.sel, mon_e.what);
      checks++;
      if (mon_a !== mon_e.exp) begin
        failures++;
        $display("FAIL %s dut%0d: got %h required %h", mon_e.name, mon_e.sel, mon_a, mon_e.exp);
      end
    end
  end

  task automatic push(input int sel, input int what, input logic [31:0] exp, input string name);
    exp_t e;
    e.sel = sel; e.what = what; e.exp = exp; e.name = name;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int sel, input int byte_addr);
    if (sel == 0) addr0 = 16'(byte_addr);
    else          addr1 = 4'(byte_addr);
  endtask

  task automatic rd(input int sel, input int w);
    set_addr(sel, w * 4 + int'($urandom_range(0, 3)));
    push(sel, W_RDATA, mmem[sel * 65536 + w], "fetch");
    step();
  endtask

  task automatic do_reload(input int sel);
    reload[sel] = 1'b1;
    valid[sel]  = 1'b0;
    step();
    reload[sel] = 1'b0;
    push(sel, W_CRST, 1, "reload_core_rst");
    push(sel, W_WL, 0, "reload_words_loaded");
    push(sel, W_OV, 0, "reload_overflow");
    push(sel, W_READY, 1, "reload_ready");
    push(sel, W_CS, 0, "reload_checksum");
    in_run[sel] = 1'b0;
  endtask

  task automatic send_byte(input int sel, input logic [7:0] d, input logic l);
    bit acc;
    int t;
    valid[sel] = 1'b1;
    data[sel]  = d;
    last[sel]  = l;
    push(sel, W_READY, 1, "ready_in_load");
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = get_ready(sel);
      @(posedge clk);
      #1;
      t++;
    end
    valid[sel] = 1'b0;
    last[sel]  = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL byte_accept_timeout dut%0d: got no accept, required accept within 50 cycles", sel);
    end
  endtask

  // Reference: word w holds image bytes 4w..4w+3 little-endian, zero padded; only the first depth words land.
  task automatic load_image(input int sel, input logic [7:0] img[$]);
    int          n, depth, nw, written;
    logic        ov;
    logic [7:0]  cs;
    logic [31:0] word;
    n       = img.size();
    depth   = (sel == 0) ? 16384 : 4;
    nw      = (n + 3) / 4;
    written = (nw > depth) ? depth : nw;
    ov      = (nw >= depth);
    cs      = 8'd0;
    foreach (img[i]) cs += img[i];
`ifndef PMEM_LOADER_CHECKSUM_EN
    cs = 8'd0;
`endif
    for (int w = 0; w < written; w++) begin
      word = 32'd0;
      for (int b = 0; b < 4; b++)
        if (4 * w + b < n) word[8*b +: 8] = img[4 * w + b];
      mmem[sel * 65536 + w] = word;
    end
    if (in_run[sel]) do_reload(sel);
    for (int i = 0; i < n; i++) begin
      send_byte(sel, img[i], i == n - 1);
      if (i != n - 1) repeat ($urandom_range(0, 2)) step();
    end
    push(sel, W_CRST, 1, "flush_core_rst");
    push(sel, W_READY, 0, "flush_ready");
    set_addr(sel, (written - 1) * 4);
    push(sel, W_RDATA, mmem[sel * 65536 + written - 1], "flush_fetch_last_word");
    step();
    push(sel, W_CRST, 0, "run_core_rst");
    push(sel, W_READY, 0, "run_ready");
    push(sel, W_WL, 32'(written), "words_loaded");
    push(sel, W_OV, {31'd0, ov}, "overflow");
    push(sel, W_CS, 32'(cs), "checksum");
    in_run[sel] = 1'b1;
    for (int w = 0; w < written; w++) rd(sel, w);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required finish within 50000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] img[$];
    logic [31:0] cs_exp;
    rst = 1'b1;
    addr0 = '0;
    addr1 = '0;
    for (int s = 0; s < 2; s++) begin
      valid[s] = 1'b0; last[s] = 1'b0; reload[s] = 1'b0; data[s] = 8'd0; in_run[s] = 1'b0;
    end
    repeat (2) step();
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      push(s, W_READY, 1, "reset_ready");
      push(s, W_CRST, 1, "reset_core_rst");
      push(s, W_WL, 0, "reset_words_loaded");
      push(s, W_OV, 0, "reset_overflow");
      push(s, W_CS, 0, "reset_checksum");
    end
    step();

    img = {8'h13, 8'h05, 8'hA0, 8'h00};
    load_image(0, img);
    addr0 = 16'h0002;
    push(0, W_RDATA, 32'h00A00513, "addi_word_at_0002");
    step();

    img = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    load_image(0, img);
    addr0 = 16'h0000;
    push(0, W_RDATA, 32'h14131211, "six_bytes_word0");
    step();
    addr0 = 16'h0004;
    push(0, W_RDATA, 32'h00001615, "six_bytes_word1_padded");
    step();

    img.delete();
    repeat (20) img.push_back(8'hFF);
    load_image(1, img);
    push(1, W_OV, 1, "overflow_20_bytes");
    push(1, W_WL, 4, "words_loaded_saturated");
    step();

    valid[0] = 1'b1;
    data[0]  = 8'h5A;
    repeat (3) begin
      step();
      push(0, W_READY, 0, "run_ignores_valid");
    end
    rd(0, 0);
    rd(0, 1);
    do_reload(0);

    send_byte(0, 8'h77, 1'b0);
    send_byte(0, 8'h66, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_run[0] = 1'b0;
    in_run[1] = 1'b0;
    push(0, W_WL, 0, "midload_reset_words_loaded");
    push(0, W_READY, 1, "midload_reset_ready");
    push(0, W_CRST, 1, "midload_reset_core_rst");
    img = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    load_image(0, img);
    addr0 = 16'h0000;
    push(0, W_RDATA, 32'hDDCCBBAA, "after_reset_word0");
    step();

    img = {8'h80, 8'h90, 8'h01};
    load_image(0, img);
`ifdef PMEM_LOADER_CHECKSUM_EN
    cs_exp = 32'h11;
`else
    cs_exp = 32'h00;
`endif
    push(0, W_CS, cs_exp, "checksum_80_90_01");
    step();

    for (int k = 0; k < 6; k++) begin
      img.delete();
      repeat ($urandom_range(1, 40)) img.push_back(8'($urandom));
      load_image(0, img);
      img.delete();
      repeat ($urandom_range(1, 24)) img.push_back(8'($urandom));
      load_image(1, img);
    end

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
